// File: rtl/vscale_hasti_sram_slave.sv
// vscale_hasti_sram_slave: word-organised SRAM behind a HASTI (AHB-lite subset)
// slave port, with programmable wait states and byte/halfword/word writes.
// Optional feature macro: VSCALE_HASTI_SLAVE_ERR_EN. When it is defined,
// out-of-range and misaligned transfers get a two-cycle ERROR response.
// When it is undefined, the word index wraps modulo DEPTH_WORDS and
// misaligned accesses are aligned down.

`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module vscale_hasti_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
    input  logic                           hwrite,
    input  logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
    input  logic [`HASTI_BURST_WIDTH-1:0]  hburst,
    input  logic                           hmastlock,
    input  logic [`HASTI_PROT_WIDTH-1:0]   hprot,
    input  logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
    input  logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
    output logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
    output logic                           hready,
    output logic [`HASTI_RESP_WIDTH-1:0]   hresp
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef VSCALE_HASTI_SLAVE_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    state_t                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           write_q, write_d;
    logic [3:0]                     mask_q, mask_d;
    logic                           hready_q, hready_d;
    logic [`HASTI_RESP_WIDTH-1:0]   hresp_q, hresp_d;

    logic [32:0]       word_off;
    logic [29:0]       word_idx;
    logic [29:0]       idx_full;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        req_mask;
    logic              req_err;
    logic              accept;
    logic              wr_en;

    // Decode the address phase: word index, byte-lane mask and error class
    always_comb begin
        word_off = {1'b0, haddr} - {1'b0, BASE_ADDR};
        word_idx = word_off[31:2];
        idx_full = word_idx % 30'(DEPTH_WORDS);
        req_idx  = idx_full[IDX_W-1:0];
        case (hsize)
            3'd0:    req_mask = 4'b0001 << haddr[1:0];
            3'd1:    req_mask = 4'b0011 << {haddr[1], 1'b0};
            default: req_mask = 4'hF;
        endcase
`ifdef VSCALE_HASTI_SLAVE_ERR_EN
        req_err = word_off[32]
               || ({2'b0, word_idx} >= 32'(DEPTH_WORDS))
               || ((hsize == 3'd1) && haddr[0])
               || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`else
        req_err = 1'b0;
`endif
    end

    assign accept = hready_q && htrans[1];

    // Data-phase next-state logic; a new transfer is only taken while hready is high
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        mask_d  = mask_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef VSCALE_HASTI_SLAVE_ERR_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = req_idx;
                    write_d = hwrite;
                    mask_d  = req_mask;
`ifdef VSCALE_HASTI_SLAVE_ERR_EN
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
        hready_d = (state_d == S_IDLE) || (state_d == S_DATA);
        hresp_d  = '0;
`ifdef VSCALE_HASTI_SLAVE_ERR_EN
        hready_d = hready_d || (state_d == S_ERR2);
        hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? '1 : '0;
`endif
    end

    // Data-phase state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            mask_q   <= '0;
            hready_q <= 1'b1;
            hresp_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            mask_q   <= mask_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    assign wr_en = (state_q == S_DATA) && write_q;

    // Byte-lane write at the end of the write data phase; a reset in that cycle drops it
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Read data: full word during a read data phase, zero otherwise
    always_comb begin
        hrdata = '0;
        if ((state_q == S_DATA) && !write_q) begin
            hrdata = mem[idx_q];
        end
    end

    assign hready = hready_q;
    assign hresp  = hresp_q;

    logic unused_bits;
    assign unused_bits = ^{hburst, hmastlock, hprot, htrans[0], word_off, idx_full, req_err};

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for vscale_hasti_sram_slave: one instance with no wait states (port 0)
// and one with two wait states (port 1). Expected data-phase results are queued
// when a transfer is driven and checked when the data phase completes.
module tb_vscale_hasti_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] haddr_a  [2];
    logic        hwrite_a [2];
    logic [2:0]  hsize_a  [2];
    logic [1:0]  htrans_a [2];
    logic [31:0] hwdata_a [2];
    logic [31:0] hrdata_a [2];
    logic        hready_a [2];
    logic [0:0]  hresp_a  [2];
    logic [2:0]  hburst   = 3'd0;
    logic [3:0]  hprot    = 4'd0;
    logic        hmastlock = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    vscale_hasti_sram_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(rst), .haddr(haddr_a[0]), .hwrite(hwrite_a[0]), .hsize(hsize_a[0]),
        .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans_a[0]),
        .hwdata(hwdata_a[0]), .hrdata(hrdata_a[0]), .hready(hready_a[0]), .hresp(hresp_a[0])
    );

    vscale_hasti_sram_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .reset(rst), .haddr(haddr_a[1]), .hwrite(hwrite_a[1]), .hsize(hsize_a[1]),
        .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans_a[1]),
        .hwdata(hwdata_a[1]), .hrdata(hrdata_a[1]), .hready(hready_a[1]), .hresp(hresp_a[1])
    );

    typedef struct {
        int          p;
        int          id;
        logic [31:0] rd;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sbq[$];
    bit   infl   [2];
    int   lowcnt [2];
    int   next_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Data-phase monitor: counts hready-low cycles, checks the completed phase against the queue head
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                infl[p]   = 1'b0;
                lowcnt[p] = 0;
            end else begin
                if (infl[p]) begin
                    if (hready_a[p]) begin
                        if (sbq.size() == 0 || sbq[0].p != p) begin
                            chk($sformatf("unexpected_data_phase_p%0d", p), 32'd1, 32'd0);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            chk($sformatf("hrdata_x%0d", e.id), hrdata_a[p], e.rd);
                            chk($sformatf("hresp_x%0d", e.id), {31'd0, hresp_a[p]}, {31'd0, e.err});
                            chk($sformatf("wait_cycles_x%0d", e.id), lowcnt[p], e.waits);
                        end
                        infl[p] = 1'b0;
                    end else begin
                        lowcnt[p]++;
                        if (sbq.size() != 0 && sbq[0].p == p) begin
                            chk($sformatf("hresp_low_x%0d", sbq[0].id), {31'd0, hresp_a[p]}, {31'd0, sbq[0].err});
                            if (lowcnt[p] > 20) begin
                                chk($sformatf("wait_timeout_x%0d", sbq[0].id), lowcnt[p], sbq[0].waits);
                                void'(sbq.pop_front());
                                infl[p] = 1'b0;
                            end
                        end
                    end
                end
                if (hready_a[p] && htrans_a[p][1]) begin
                    infl[p]   = 1'b1;
                    lowcnt[p] = 0;
                end
            end
        end
    end

    // Drive one address phase and hold it until accepted; returns cycles spent
    task automatic issue(input int p, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_waits, output int cyc);
        exp_t e;
        logic rdy;
        e.p = p; e.id = next_id; e.rd = exp_rd; e.err = exp_err; e.waits = exp_waits;
        next_id++;
        sbq.push_back(e);
        haddr_a[p]  = a;
        hwrite_a[p] = wr;
        hsize_a[p]  = sz;
        htrans_a[p] = 2'd2;
        cyc = 0;
        forever begin
            rdy = hready_a[p];
            @(posedge clk); #1;
            cyc++;
            if (rdy) break;
            if (cyc > 50) begin
                chk("accept_timeout", cyc, 32'd0);
                break;
            end
        end
        if (wr) hwdata_a[p] = wd;
    endtask

    task automatic idle_drain(input int p);
        htrans_a[p] = 2'd0;
        for (int k = 0; k < 40; k++) begin
            if (sbq.size() == 0 && !infl[p]) break;
            @(posedge clk); #1;
        end
        chk($sformatf("drain_p%0d", p), sbq.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int p = 0; p < 2; p++) begin
            haddr_a[p] = '0; hwrite_a[p] = 1'b0; hsize_a[p] = 3'd2;
            htrans_a[p] = 2'd2; hwdata_a[p] = '0;
        end

        // Reset held three cycles with NONSEQ on the bus
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rst_hready_p%0d", p), {31'd0, hready_a[p]}, 32'd1);
                chk($sformatf("rst_hresp_p%0d", p), {31'd0, hresp_a[p]}, 32'd0);
                chk($sformatf("rst_hrdata_p%0d", p), hrdata_a[p], 32'd0);
            end
        end
        htrans_a[0] = 2'd0;
        htrans_a[1] = 2'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        // No wait states: write then back-to-back read
        issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, c);
        chk("first_accept_cycles", c, 32'd1);
        issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, c);
        chk("b2b_accept_cycles", c, 32'd1);

        // Byte lanes
        issue(0, 1'b1, 3'd2, 32'h20, 32'h00000000, 32'h0, 1'b0, 0, c);
        issue(0, 1'b1, 3'd0, 32'h22, 32'hAABBCCDD, 32'h0, 1'b0, 0, c);
        issue(0, 1'b1, 3'd1, 32'h20, 32'h11223344, 32'h0, 1'b0, 0, c);
        issue(0, 1'b0, 3'd2, 32'h20, 32'h0, 32'h00BB3344, 1'b0, 0, c);
        chk("raw_accept_cycles", c, 32'd1);
        idle_drain(0);

        issue(0, 1'b1, 3'd2, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 0, c);
`ifdef VSCALE_HASTI_SLAVE_ERR_EN
        // Out-of-range and misaligned transfers answer ERROR; memory untouched
        issue(0, 1'b1, 3'd2, 32'h1000, 32'h55555555, 32'h0, 1'b1, 1, c);
        issue(0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 0, c);
        chk("after_err_accept_cycles", c, 32'd2);
        issue(0, 1'b0, 3'd2, 32'h2, 32'h0, 32'h0, 1'b1, 1, c);
        issue(0, 1'b0, 3'd1, 32'h1, 32'h0, 32'h0, 1'b1, 1, c);
        chk("err_to_err_accept_cycles", c, 32'd2);
        issue(0, 1'b0, 3'd0, 32'h3, 32'h0, 32'h0BADF00D, 1'b0, 0, c);
`else
        // Index wraps modulo depth; misaligned accesses align down
        issue(0, 1'b1, 3'd2, 32'h1000, 32'h55555555, 32'h0, 1'b0, 0, c);
        issue(0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h55555555, 1'b0, 0, c);
        issue(0, 1'b0, 3'd2, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0, 0, c);
        issue(0, 1'b0, 3'd1, 32'h23, 32'h0, 32'h00BB3344, 1'b0, 0, c);
`endif
        idle_drain(0);

        // Two wait states: NONSEQ held during waits is taken only on the hready-high cycle
        issue(1, 1'b1, 3'd2, 32'h10, 32'hCAFEBABE, 32'h0, 1'b0, 2, c);
        issue(1, 1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEBABE, 1'b0, 2, c);
        chk("held_accept_cycles", c, 32'd3);
        idle_drain(1);

        // Reset during the wait states of a write drops the write
        issue(1, 1'b1, 3'd2, 32'h40, 32'h12345678, 32'h0, 1'b0, 2, c);
        idle_drain(1);
        haddr_a[1] = 32'h40; hwrite_a[1] = 1'b1; hsize_a[1] = 3'd2; htrans_a[1] = 2'd2;
        @(posedge clk); #1;
        htrans_a[1] = 2'd0;
        hwdata_a[1] = 32'hCAFEF00D;
        chk("wait_hready_low", {31'd0, hready_a[1]}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("hready_after_reset", {31'd0, hready_a[1]}, 32'd1);
        chk("hresp_after_reset", {31'd0, hresp_a[1]}, 32'd0);
        issue(1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 1'b0, 2, c);
        idle_drain(1);

        // Idle bus leaves hrdata at zero
        chk("idle_hrdata_p0", hrdata_a[0], 32'd0);
        chk("idle_hrdata_p1", hrdata_a[1], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
